// File: rtl/sdm_pkg.sv
// Shared types and arithmetic helpers for the multi-channel sigma-delta modulator.
// Helpers compute at a fixed wide width; callers truncate to their integrator width.
package sdm_pkg;

    typedef enum logic {
        ORDER_1 = 1'b0,
        ORDER_2 = 1'b1
    } order_e;

    localparam int unsigned CALC_W = 64;
    typedef logic signed [CALC_W-1:0] calc_t;

    // Offset-binary w-bit value to signed: invert the MSB, then sign-extend.
    function automatic calc_t ob2s(input logic [CALC_W-1:0] x, input int unsigned w);
        logic [CALC_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < CALC_W; i++) begin
            if (i + 1 < w) r[i] = x[i];
            else           r[i] = ~x[w-1];
        end
        return signed'(r);
    endfunction

    // a + b clamped to the signed w-bit range; ovf flags any clamp.
    function automatic calc_t satadd(input calc_t a, input calc_t b, input int unsigned w,
                                     output logic ovf);
        calc_t sum;
        calc_t hi;
        calc_t lo;
        sum = a + b;
        hi  = (calc_t'(1) <<< (w - 1)) - calc_t'(1);
        lo  = -(calc_t'(1) <<< (w - 1));
        ovf = 1'b0;
        if (sum > hi) begin
            sum = hi;
            ovf = 1'b1;
        end else if (sum < lo) begin
            sum = lo;
            ovf = 1'b1;
        end
        return sum;
    endfunction

endpackage

// File: rtl/sdm_core.sv
// One modulator channel: 1st/2nd-order saturating integrators, 1-bit quantiser,
// feedback and a sticky saturation flag.
module sdm_core
    import sdm_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned GUARD = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  order_e           order_q,
    input  logic             clr_int,
    input  logic [WIDTH-1:0] sample,
    input  logic             sat_clr,
    output logic             dout,
    output logic             sat
);

    localparam int unsigned IW     = WIDTH + GUARD;
    localparam calc_t       FB_MAG = calc_t'(1) <<< (WIDTH - 1);

    logic signed [IW-1:0] i1;
    logic signed [IW-1:0] i2;
    logic signed [IW-1:0] n1;
    logic signed [IW-1:0] n2;
    calc_t                xs;
    calc_t                fb;
    logic                 ovf1;
    logic                 ovf2;
    logic                 set_sat;

    always_comb begin
        ovf1    = 1'b0;
        ovf2    = 1'b0;
        xs      = ob2s({{(CALC_W-WIDTH){1'b0}}, sample}, WIDTH);
        fb      = dout ? FB_MAG : -FB_MAG;
        // Both stages read the pre-update i1.
        n1      = IW'(satadd(calc_t'(i1), xs - fb, IW, ovf1));
        n2      = IW'(satadd(calc_t'(i2), calc_t'(i1) - fb, IW, ovf2));
        set_sat = en && !clr_int && (ovf1 || (order_q == ORDER_2 && ovf2));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i1   <= '0;
            i2   <= '0;
            dout <= 1'b0;
            sat  <= 1'b0;
        end else begin
            if (en) begin
                if (clr_int) begin
                    i1   <= '0;
                    i2   <= '0;
                    dout <= 1'b0;
                end else if (order_q == ORDER_2) begin
                    i1   <= n1;
                    i2   <= n2;
                    dout <= ~n2[IW-1];
                end else begin
                    i1   <= n1;
                    i2   <= '0;
                    dout <= ~n1[IW-1];
                end
            end
            sat <= (sat & ~sat_clr) | set_sat;
        end
    end

endmodule

// File: rtl/sdm_nch.sv
// Multi-channel sigma-delta DAC modulator: shared OSR counter, double-buffered
// sample handshake, order select at wrap and sticky underrun, one sdm_core per channel.
module sdm_nch
    import sdm_pkg::*;
#(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned NCH      = 2,
    parameter int unsigned GUARD    = 6,
    parameter int unsigned OSR_LOG2 = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 order,
    input  logic [NCH*WIDTH-1:0] din,
    input  logic                 din_valid,
    output logic                 din_ready,
    output logic [NCH-1:0]       dout,
    output logic                 tick,
    output logic [NCH-1:0]       sat,
    output logic                 underrun,
    input  logic                 sat_clr
);

    localparam logic [WIDTH-1:0] MIDSCALE = {1'b1, {(WIDTH-1){1'b0}}};

    logic [OSR_LOG2-1:0]  osr_cnt;
    logic [NCH*WIDTH-1:0] buffer;
    logic [NCH*WIDTH-1:0] active;
    logic                 pending;
    order_e               order_q;
    logic                 wrap;
    logic                 accept;
    logic                 load;
    logic                 clr_int;

    always_comb begin
        wrap    = enable && (osr_cnt == '1);
        accept  = din_valid && !pending;
        load    = wrap && pending;
        clr_int = load && (order_e'(order) != order_q);
    end

    assign din_ready = !pending;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            osr_cnt  <= '0;
            tick     <= 1'b0;
            buffer   <= '0;
            active   <= {NCH{MIDSCALE}};
            pending  <= 1'b0;
            order_q  <= ORDER_1;
            underrun <= 1'b0;
        end else begin
            if (enable) begin
                osr_cnt <= osr_cnt + 1'b1;
                tick    <= wrap;
            end
            if (load) begin
                active  <= buffer;
                order_q <= order_e'(order);
            end
            // accept needs !pending and load needs pending, so they never overlap.
            if (accept) begin
                buffer  <= din;
                pending <= 1'b1;
            end else if (load) begin
                pending <= 1'b0;
            end
            underrun <= (underrun & ~sat_clr) | (wrap & ~pending);
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        sdm_core #(
            .WIDTH(WIDTH),
            .GUARD(GUARD)
        ) u_core (
            .clk     (clk),
            .rst     (reset),
            .en      (enable),
            .order_q (order_q),
            .clr_int (clr_int),
            .sample  (active[c*WIDTH +: WIDTH]),
            .sat_clr (sat_clr),
            .dout    (dout[c]),
            .sat     (sat[c])
        );
    end

endmodule

// File: tb/tb_sdm_nch.sv
// Scoreboard bench for sdm_nch: directed stimulus queues expectations per cycle,
// a negedge monitor pops and compares them. A GUARD=0 copy shares the inputs.
module tb_sdm_nch;

    localparam int unsigned WIDTH    = 16;
    localparam int unsigned NCH      = 2;
    localparam int unsigned OSR_LOG2 = 3;

    typedef enum {
        S_DOUT, S_DOUT_G0, S_READY, S_TICK, S_SAT, S_SAT_G0, S_UNDER,
        S_G0_MISC, S_CNT0, S_CNT1, S_CLR0, S_CLR1
    } sel_e;

    typedef struct {
        int    cyc;
        sel_e  sel;
        int    lo;
        int    hi;
        string name;
    } exp_t;

    logic                 clk;
    logic                 reset;
    logic                 enable;
    logic                 order;
    logic [NCH*WIDTH-1:0] din;
    logic                 din_valid;
    logic                 sat_clr;
    logic                 din_ready;
    logic [NCH-1:0]       dout;
    logic                 tick;
    logic [NCH-1:0]       sat;
    logic                 underrun;
    logic                 din_ready_g0;
    logic [NCH-1:0]       dout_g0;
    logic                 tick_g0;
    logic [NCH-1:0]       sat_g0;
    logic                 underrun_g0;

    exp_t sb[$];
    int   cyc;
    int   c0;
    int   ones0;
    int   ones1;
    int   total;
    int   bad;

    sdm_nch #(.WIDTH(WIDTH), .NCH(NCH), .GUARD(6), .OSR_LOG2(OSR_LOG2)) dut (
        .clk(clk), .reset(reset), .enable(enable), .order(order), .din(din),
        .din_valid(din_valid), .din_ready(din_ready), .dout(dout), .tick(tick),
        .sat(sat), .underrun(underrun), .sat_clr(sat_clr)
    );

    sdm_nch #(.WIDTH(WIDTH), .NCH(NCH), .GUARD(0), .OSR_LOG2(OSR_LOG2)) dut_g0 (
        .clk(clk), .reset(reset), .enable(enable), .order(order), .din(din),
        .din_valid(din_valid), .din_ready(din_ready_g0), .dout(dout_g0), .tick(tick_g0),
        .sat(sat_g0), .underrun(underrun_g0), .sat_clr(sat_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc <= cyc + 1;
        end
    end

    function automatic int probe(input sel_e s);
        case (s)
            S_DOUT:    return int'(dout);
            S_DOUT_G0: return int'(dout_g0);
            S_READY:   return int'(din_ready);
            S_TICK:    return int'(tick);
            S_SAT:     return int'(sat);
            S_SAT_G0:  return int'(sat_g0);
            S_UNDER:   return int'(underrun);
            S_G0_MISC: return int'({din_ready_g0, tick_g0, underrun_g0});
            S_CNT0:    return ones0;
            S_CNT1:    return ones1;
            default:   return -1;
        endcase
    endfunction

    // Monitor: accumulate ones, then resolve every expectation due this cycle.
    initial begin
        exp_t e;
        int   got;
        ones0 = 0;
        ones1 = 0;
        total = 0;
        bad   = 0;
        forever begin
            @(negedge clk);
            if (dout[0]) ones0++;
            if (dout[1]) ones1++;
            while (sb.size() != 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                case (e.sel)
                    S_CLR0:  ones0 = 0;
                    S_CLR1:  ones1 = 0;
                    default: begin
                        got = probe(e.sel);
                        total++;
                        if (got < e.lo || got > e.hi) begin
                            bad++;
                            $display("FAIL %s t=%0d: got %0d, want %0d..%0d",
                                     e.name, cyc - c0, got, e.lo, e.hi);
                        end
                    end
                endcase
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input sel_e s, input int lo, input int hi, input string nm);
        sb.push_back('{cyc, s, lo, hi, nm});
    endtask

    task automatic chk1(input sel_e s, input int v, input string nm);
        chk(s, v, v, nm);
    endtask

    task automatic run_to(input int t);
        while (cyc - c0 < t) step();
    endtask

    initial begin
        int o1_seq[8];
        int o2_seq[8];
        o1_seq = '{3, 3, 0, 3, 0, 3, 0, 3};
        o2_seq = '{3, 3, 3, 3, 3, 0, 0, 3};

        reset = 1'b1; enable = 1'b0; order = 1'b0;
        din = '0; din_valid = 1'b0; sat_clr = 1'b0;
        c0 = 0;
        repeat (2) step();

        // Pre-run with order 2 and a sample in flight, then reset mid-operation.
        reset = 1'b0; enable = 1'b1; order = 1'b1;
        din = {16'hFFFF, 16'h1234}; din_valid = 1'b1;
        c0 = cyc;
        run_to(8);  chk1(S_READY, 1, "pre_wrap_consumes");
        run_to(9);  chk1(S_READY, 0, "pre_second_accept");
        din_valid = 1'b0;
        run_to(10);
        reset = 1'b1; order = 1'b0;
        chk1(S_DOUT, 0, "rst_dout");
        chk1(S_DOUT_G0, 0, "rst_dout_g0");
        chk1(S_READY, 1, "rst_ready");
        chk1(S_SAT, 0, "rst_sat");
        chk1(S_SAT_G0, 0, "rst_sat_g0");
        chk1(S_TICK, 0, "rst_tick");
        chk1(S_UNDER, 0, "rst_underrun");
        run_to(13);
        reset = 1'b0;
        c0 = cyc;
        chk1(S_CLR0, 0, "clr0");

        // Order 1, midscale active sample.
        for (int i = 1; i <= 8; i++) begin
            run_to(i);
            chk1(S_DOUT, o1_seq[i-1], "o1_dout");
            chk1(S_DOUT_G0, (i % 2 == 1) ? 3 : 0, "g0_o1_dout");
            chk1(S_TICK, (i == 8) ? 1 : 0, "first_tick");
            chk1(S_UNDER, (i == 8) ? 1 : 0, "underrun_first_wrap");
            if (i == 1) begin
                chk1(S_SAT_G0, 3, "g0_first_clamp");
                chk1(S_SAT, 0, "no_sat_guarded");
                chk1(S_READY, 1, "ready_after_reset");
            end
        end
        chk1(S_G0_MISC, 7, "g0_ready_tick_underrun");
        run_to(9);  chk1(S_TICK, 0, "tick_one_cycle");
        run_to(64); chk(S_CNT0, 32, 33, "o1_ones_64");

        // Underrun clear, then clear coincident with a wrap.
        run_to(66); chk1(S_UNDER, 1, "underrun_sticky"); sat_clr = 1'b1;
        run_to(67); sat_clr = 1'b0;
        chk1(S_UNDER, 0, "underrun_cleared");
        chk1(S_SAT_G0, 0, "sat_cleared");
        run_to(71); chk1(S_UNDER, 0, "underrun_still_clear"); sat_clr = 1'b1;
        run_to(72); sat_clr = 1'b0;
        chk1(S_UNDER, 1, "set_beats_clear");
        chk1(S_TICK, 1, "tick_at_72");
        chk1(S_DOUT, 3, "dout_at_72");

        // Freeze while a sample is accepted; A then B back-to-back, order -> 2.
        enable = 1'b0;
        run_to(73);
        din = {16'hC000, 16'hC000}; din_valid = 1'b1; order = 1'b1;
        chk1(S_DOUT, 3, "frozen_dout");
        run_to(74);
        din = {16'h4000, 16'hC000};
        chk1(S_READY, 0, "accept_while_frozen");
        chk1(S_DOUT, 3, "frozen_dout");
        run_to(76);
        enable = 1'b1;
        chk1(S_TICK, 1, "frozen_tick");
        chk1(S_DOUT, 3, "frozen_dout");
        run_to(77); chk1(S_TICK, 0, "tick_after_resume"); chk1(S_DOUT, 0, "resume_dout");
        run_to(83); chk1(S_READY, 0, "busy_until_wrap"); chk1(S_DOUT, 0, "pre_clear_dout");
        run_to(84);
        chk1(S_TICK, 1, "wrap_tick");
        chk1(S_READY, 1, "ready_at_wrap");
        chk1(S_DOUT, 0, "order_change_clears");
        chk1(S_SAT_G0, 0, "no_sat_on_clear");
        chk1(S_CLR0, 0, "clr0");
        for (int i = 85; i <= 92; i++) begin
            run_to(i);
            chk1(S_DOUT, o2_seq[i-85], "o2_dout_A");
            if (i == 85) begin
                din_valid = 1'b0;
                chk1(S_READY, 0, "B_accepted_after_wrap");
                chk1(S_SAT_G0, 3, "g0_o2_clamp");
                chk1(S_SAT, 0, "o2_no_sat");
            end
        end
        chk1(S_READY, 1, "B_loaded");
        chk1(S_TICK, 1, "tick_at_92");
        chk1(S_CLR1, 0, "clr1");

        run_to(93); sat_clr = 1'b1;
        run_to(94); sat_clr = 1'b0; chk1(S_UNDER, 0, "underrun_cleared2");
        run_to(99);  chk1(S_UNDER, 0, "underrun_before_wrap");
        run_to(100); chk1(S_UNDER, 1, "underrun_retained_active");

        run_to(1108); chk(S_CNT0, 764, 772, "o2_ones_ch0");
        run_to(1116);
        chk(S_CNT1, 252, 260, "o2_ones_ch1");
        chk1(S_SAT, 0, "o2_no_sat_end");

        run_to(1119);
        if (sb.size() != 0) begin
            bad += sb.size();
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
